deca_qsys_key_pio: RTL and testbench
====================================

DECA_QSYS_KEY_PIO -- requirements
Module: deca_qsys_key_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of key inputs (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, number of stable synchronized cycles required to accept a level change (>=2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port in_port  input  WIDTH  asynchronous key levels, active-low (1 = released).
REQ-010 SHALL have port readdata  output  32  read data, zero read wait states.
REQ-011 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 SHALL keep a per-bit debounced level db and a per-bit counter cnt, width clog2(DEBOUNCE_CYCLES).
REQ-014 SHALL, per bit and per clock edge: if s2 == db, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, db <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-015 SHALL thus update db on the DEBOUNCE_CYCLES-th consecutive edge where s2 differs, i.e. DEBOUNCE_CYCLES+2 edges after a stable in_port change is first sampled.
REQ-016 SHALL restart the count (cnt <= 0) whenever s2 returns to db before acceptance; shorter glitches never reach db.
REQ-017 SHALL set edgecapture[i] on the same edge that db[i] changes 1 -> 0 (press); 0 -> 1 (release) SHALL NOT set it.
REQ-018 SHALL decode registers: addr 0 = db (read-only, writes ignored); addr 1 = reads 0, writes ignored; addr 2 = interruptmask (R/W, writedata[WIDTH-1:0]); addr 3 = edgecapture (read; write-1-to-clear per bit).
REQ-019 SHALL perform a write when chipselect && !write_n, taking effect at that clock edge.
REQ-020 SHALL drive readdata combinationally from address (no chipselect qualification), register in bits [WIDTH-1:0], upper bits 0.
REQ-021 SHALL, when a write-1-clear and a new press edge hit the same bit on the same edge, leave the bit set (set wins).
REQ-022 SHALL drive irq = OR over i of (edgecapture[i] & interruptmask[i]), combinational from registers (irq follows register change with zero added latency).
REQ-023 SHALL treat each bit independently; simultaneous events on different bits SHALL not interact.

Reset
REQ-024 SHALL on reset_n low, asynchronously: s1, s2, db <= all ones; cnt <= 0; interruptmask <= 0; edgecapture <= 0; hence irq = 0, readdata(addr 0) = all ones.
REQ-025 SHALL, since db resets to released, generate no edgecapture at reset release when keys are released; a key held through reset is captured DEBOUNCE_CYCLES+2 edges after release.
REQ-026 SHALL abandon any in-progress count on reset mid-operation; counting restarts from 0 after release.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover: reset, in_port=2'b11 -> addr0 reads 0x3, addr2/addr3 read 0, irq=0.
REQ-028 SHALL cover: in_port[0] 1->0 held -> addr0 reads 0x2 and addr3 reads 0x1 exactly 6 edges later; irq stays 0; write addr2=0x1 -> irq=1 after that edge.
REQ-029 SHALL cover: in_port[0] low for 3 cycles then high (bounce) -> addr0 stays 0x3, addr3 stays 0, irq 0.
REQ-030 SHALL cover: with edgecapture=0x3, mask=0x3, write addr3=0x1 -> addr3 reads 0x2, irq=1; write addr3=0x2 on same edge as a new bit-1 press -> addr3 reads 0x2.
REQ-031 SHALL cover: release in_port[0] 0->1 -> addr0 bit0 returns to 1 after 6 edges, addr3 unchanged.
REQ-032 SHALL cover: reset_n pulsed low at cnt=2 of a press -> all registers at reset values immediately; press still held -> captured 6 edges after reset release.

Source files
------------

// File: rtl/deca_qsys_key_pio.sv
// -----------------------------------------------------------------------------
// deca_qsys_key_pio
//   Debounced push-button PIO with an Avalon-MM slave register interface.
//   Each key input is synchronized (2 flops), then debounced: a level change is
//   only accepted after DEBOUNCE_CYCLES consecutive synchronized samples that
//   disagree with the current debounced level. A debounced press (1 -> 0) sets
//   the matching edgecapture bit; masked edgecapture bits drive irq.
//
// Ports
//   clk         in   single clock
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] word address (0 data, 1 reserved, 2 mask, 3 edgecap)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   in_port     in   [WIDTH-1:0] raw key levels, active-low (1 = released)
//   readdata    out  [31:0] combinational read data, zero wait states
//   irq         out  level interrupt, OR of (edgecapture & interruptmask)
// -----------------------------------------------------------------------------
module deca_qsys_key_pio #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] db_q, db_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] ecap_q, ecap_d;
   logic [WIDTH-1:0] press;
   logic             wr_en;

   // Upper write-data bits have no destination register.
   logic unused_wdata;
   assign unused_wdata = ^writedata[31:WIDTH];

   assign wr_en = chipselect & ~write_n;

   // Debounce: count consecutive disagreeing samples; any agreeing sample
   // restarts the count, so glitches shorter than DEBOUNCE_CYCLES are dropped.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Press = debounced level falling on this edge.
   assign press = db_q & ~db_d;

   always_comb begin
      mask_d = mask_q;
      ecap_d = ecap_q;
      if (wr_en && address == 2'd2) begin
         mask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && address == 2'd3) begin
         ecap_d = ecap_q & ~writedata[WIDTH-1:0];
      end
      // Applied after the clear so a coincident press keeps the bit set.
      ecap_d = ecap_d | press;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= '1;
         s2_q   <= '1;
         db_q   <= '1;
         mask_q <= '0;
         ecap_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q   <= in_port;
         s2_q   <= s1_q;
         db_q   <= db_d;
         mask_q <= mask_d;
         ecap_q <= ecap_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(db_q);
         2'd2:    readdata = 32'(mask_q);
         2'd3:    readdata = 32'(ecap_q);
         default: readdata = '0;
      endcase
   end

   assign irq = |(ecap_q & mask_q);

endmodule

// File: tb/tb_deca_qsys_key_pio.sv
module tb_deca_qsys_key_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [1:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      string       tag;
      logic [1:0]  addr;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t sb[$];

   deca_qsys_key_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
      rd_exp_t r;
      r.tag  = tag;
      r.addr = a;
      r.exp  = e;
      sb.push_back(r);
   endtask

   // Pop every queued expectation and compare against a live read.
   task automatic drain();
      rd_exp_t r;
      while (sb.size() > 0) begin
         r = sb.pop_front();
         address = r.addr;
         #1;
         n_total++;
         assert (readdata === r.exp) n_pass++;
         else $error("FAIL %s: readdata=%h expected=%h", r.tag, readdata, r.exp);
      end
   endtask

   task automatic chk_irq(input string tag, input logic e);
      n_total++;
      assert (irq === e) n_pass++;
      else $error("FAIL %s: irq=%b expected=%b", tag, irq, e);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 2'b11;
      tick(2);

      // Reset state
      expect_rd("rst_data", 2'd0, 32'h3);
      expect_rd("rst_mask", 2'd2, 32'h0);
      expect_rd("rst_ecap", 2'd3, 32'h0);
      drain();
      chk_irq("rst_irq", 1'b0);

      reset_n = 1'b1;
      tick(10);
      expect_rd("idle_ecap", 2'd3, 32'h0);
      drain();

      // Bounce: bit0 low for 3 cycles only
      in_port = 2'b10;
      tick(3);
      in_port = 2'b11;
      tick(10);
      expect_rd("bounce_data", 2'd0, 32'h3);
      expect_rd("bounce_ecap", 2'd3, 32'h0);
      drain();
      chk_irq("bounce_irq", 1'b0);

      // Register decode: writes to addr 0 and 1 ignored
      wr(2'd0, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      expect_rd("ro_data", 2'd0, 32'h3);
      expect_rd("addr1_zero", 2'd1, 32'h0);
      drain();

      // Press bit0: accepted exactly on the 6th edge
      in_port = 2'b10;
      tick(5);
      expect_rd("press0_e5_data", 2'd0, 32'h3);
      expect_rd("press0_e5_ecap", 2'd3, 32'h0);
      drain();
      tick(1);
      expect_rd("press0_e6_data", 2'd0, 32'h2);
      expect_rd("press0_e6_ecap", 2'd3, 32'h1);
      drain();
      chk_irq("press0_unmasked_irq", 1'b0);
      wr(2'd2, 32'h1);
      chk_irq("mask0_irq", 1'b1);
      expect_rd("mask_rd", 2'd2, 32'h1);
      drain();

      // Press bit1 too, then partial clear
      in_port = 2'b00;
      tick(6);
      expect_rd("press1_data", 2'd0, 32'h0);
      expect_rd("press1_ecap", 2'd3, 32'h3);
      drain();
      wr(2'd2, 32'h3);
      wr(2'd3, 32'h1);
      expect_rd("clr0_ecap", 2'd3, 32'h2);
      drain();
      chk_irq("clr0_irq", 1'b1);

      // Release bit1 (no capture), then re-press coinciding with a clear
      in_port = 2'b10;
      tick(6);
      expect_rd("rel1_data", 2'd0, 32'h2);
      expect_rd("rel1_ecap", 2'd3, 32'h2);
      drain();
      in_port = 2'b00;
      tick(5);
      wr(2'd3, 32'h2);
      expect_rd("setwins_data", 2'd0, 32'h0);
      expect_rd("setwins_ecap", 2'd3, 32'h2);
      drain();
      chk_irq("setwins_irq", 1'b1);
      wr(2'd3, 32'h2);
      expect_rd("clr1_ecap", 2'd3, 32'h0);
      drain();
      chk_irq("clr1_irq", 1'b0);

      // Release bit0: db returns after 6 edges, edgecapture unchanged
      in_port = 2'b01;
      tick(5);
      expect_rd("rel0_e5_data", 2'd0, 32'h0);
      drain();
      tick(1);
      expect_rd("rel0_e6_data", 2'd0, 32'h1);
      expect_rd("rel0_ecap", 2'd3, 32'h0);
      drain();
      chk_irq("rel0_irq", 1'b0);

      // Release all, then reset mid-count of a press
      in_port = 2'b11;
      tick(8);
      expect_rd("relall_data", 2'd0, 32'h3);
      drain();
      in_port = 2'b10;
      tick(4);
      reset_n = 1'b0;
      expect_rd("midrst_data", 2'd0, 32'h3);
      expect_rd("midrst_mask", 2'd2, 32'h0);
      expect_rd("midrst_ecap", 2'd3, 32'h0);
      drain();
      chk_irq("midrst_irq", 1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      expect_rd("postrst_e5_data", 2'd0, 32'h3);
      drain();
      tick(1);
      expect_rd("postrst_e6_data", 2'd0, 32'h2);
      expect_rd("postrst_e6_ecap", 2'd3, 32'h1);
      drain();
      chk_irq("postrst_irq", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
